// File: rtl/seven_seg_scan_decoder.sv
// Receive side of a multiplexed active-low seven-segment display: recovers each
// digit's code from the scanned anode/segment lines and publishes frames once stable.
module seven_seg_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int SETTLE        = 4,
  parameter int STABLE_FRAMES = 2,
  parameter int TIMEOUT       = 1048576
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DIGITS-1:0]   an,
  input  logic [6:0]          seg,
  output logic [4*DIGITS-1:0] digits,
  output logic                valid,
  output logic                update,
  output logic                err_multi
);
  localparam int IW = $clog2(DIGITS);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [DIGITS-1:0]   r_anMeta, r_anSync;
  logic [6:0]          r_segMeta, r_segSync;
  logic [7:0]          r_run;
  logic [IW-1:0]       r_idx;
  logic [DIGITS-1:0]   r_seen;
  logic [4*DIGITS-1:0] r_candBuf, r_lastFrame, r_digits;
  logic [3:0]          r_stable;
  logic [TW-1:0]       r_timer;
  logic                r_valid, r_update, r_errMulti;

  logic [DIGITS-1:0]   w_anLow;
  logic                w_oneHot, w_multi, w_sameIdx, w_sample;
  logic                w_frameDone, w_expire, w_publish;
  logic [IW-1:0]       w_idx;
  logic [7:0]          w_nextRun;
  logic [3:0]          w_code;

  function automatic logic [3:0] decodeGlyph(input logic [6:0] s);
    case (s)
      7'b1000000: decodeGlyph = 4'h0;
      7'b1111001: decodeGlyph = 4'h1;
      7'b0100100: decodeGlyph = 4'h2;
      7'b0110000: decodeGlyph = 4'h3;
      7'b0011001: decodeGlyph = 4'h4;
      7'b0010010: decodeGlyph = 4'h5;
      7'b0000010: decodeGlyph = 4'h6;
      7'b1111000: decodeGlyph = 4'h7;
      7'b0000000: decodeGlyph = 4'h8;
      7'b0010000: decodeGlyph = 4'h9;
      7'b1011100: decodeGlyph = 4'hA;
      7'b1100011: decodeGlyph = 4'hB;
      7'b1111111: decodeGlyph = 4'hC;
      default:    decodeGlyph = 4'hF;
    endcase
  endfunction

  // A sample fires once per activation: on the cycle the run reaches SETTLE,
  // counting a fresh index as a new activation even when SETTLE is 1.
  always_comb begin
    w_anLow   = ~r_anSync;
    w_oneHot  = (w_anLow != '0) && ((w_anLow & (w_anLow - DIGITS'(1))) == '0);
    w_multi   = (w_anLow != '0) && !w_oneHot;
    w_idx     = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (w_anLow[k]) w_idx = IW'(k);
    end
    w_sameIdx = (w_idx == r_idx);
    if (!w_oneHot)                w_nextRun = '0;
    else if (!w_sameIdx)          w_nextRun = 8'd1;
    else if (r_run >= 8'(SETTLE)) w_nextRun = 8'(SETTLE);
    else                          w_nextRun = r_run + 8'd1;
    w_sample    = w_oneHot && (w_nextRun == 8'(SETTLE)) &&
                  !(w_sameIdx && (r_run == 8'(SETTLE)));
    w_code      = decodeGlyph(r_segSync);
    w_frameDone = &r_seen;
    w_expire    = (r_timer == TW'(1)) && !w_sample;
    w_publish   = (r_stable >= 4'(STABLE_FRAMES)) &&
                  (!r_valid || (r_lastFrame != r_digits)) && !w_expire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_anMeta    <= '1;
      r_anSync    <= '1;
      r_segMeta   <= '1;
      r_segSync   <= '1;
      r_run       <= '0;
      r_idx       <= '0;
      r_seen      <= '0;
      r_candBuf   <= '0;
      r_lastFrame <= '0;
      r_digits    <= '0;
      r_stable    <= '0;
      r_timer     <= '0;
      r_valid     <= 1'b0;
      r_update    <= 1'b0;
      r_errMulti  <= 1'b0;
    end else begin
      r_anMeta  <= an;
      r_anSync  <= r_anMeta;
      r_segMeta <= seg;
      r_segSync <= r_segMeta;

      r_run <= w_nextRun;
      if (w_oneHot) r_idx <= w_idx;
      if (w_multi) r_errMulti <= 1'b1;
      if (w_sample) r_candBuf[{w_idx, 2'b00} +: 4] <= w_code;

      // A sample for the next frame landing on the completion cycle keeps its seen bit.
      if (w_expire)         r_seen <= '0;
      else if (w_frameDone) r_seen <= w_sample ? w_anLow : '0;
      else if (w_sample)    r_seen <= r_seen | w_anLow;

      if (w_expire) begin
        r_stable <= '0;
      end else if (w_frameDone) begin
        if (r_candBuf == r_lastFrame) begin
          if (r_stable != 4'd15) r_stable <= r_stable + 4'd1;
        end else begin
          r_lastFrame <= r_candBuf;
          r_stable    <= 4'd1;
        end
      end

      if (w_sample)            r_timer <= TW'(TIMEOUT);
      else if (r_timer != '0)  r_timer <= r_timer - TW'(1);

      // digits is held across a timeout; only valid drops.
      r_update <= w_publish;
      if (w_expire) begin
        r_valid <= 1'b0;
      end else if (w_publish) begin
        r_valid  <= 1'b1;
        r_digits <= r_lastFrame;
      end
    end
  end

  assign digits    = r_digits;
  assign valid     = r_valid;
  assign update    = r_update;
  assign err_multi = r_errMulti;
endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Randomized scoreboard bench for seven_seg_scan_decoder: a frame-level model predicts
// each publish, and a monitor pops the prediction whenever update pulses.
module tb_seven_seg_scan_decoder;
  localparam int DIGITS        = 4;
  localparam int SETTLE        = 4;
  localparam int STABLE_FRAMES = 2;
  localparam int TIMEOUT       = 300;

  logic                clk = 1'b0;
  logic                rst;
  logic [DIGITS-1:0]   an;
  logic [6:0]          seg;
  logic [4*DIGITS-1:0] digits;
  logic                valid, update, errMulti;

  int passCount  = 0;
  int checkCount = 0;

  logic [4*DIGITS-1:0] expQ[$];
  logic [6:0]          glyph[13];
  logic [4*DIGITS-1:0] mLast = '0;
  logic [4*DIGITS-1:0] mPub  = '0;
  int                  mStable = 0;
  bit                  mValid  = 1'b0;
  bit                  mErr    = 1'b0;

  always #5 clk = ~clk;

  seven_seg_scan_decoder #(
    .DIGITS(DIGITS), .SETTLE(SETTLE), .STABLE_FRAMES(STABLE_FRAMES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .an(an), .seg(seg),
    .digits(digits), .valid(valid), .update(update), .err_multi(errMulti)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [3:0] decodeModel(input logic [6:0] p);
    decodeModel = 4'hF;
    for (int i = 0; i < 13; i++) begin
      if (glyph[i] == p) decodeModel = 4'(i);
    end
  endfunction

  function automatic logic [7*DIGITS-1:0] buildSegs(input logic [4*DIGITS-1:0] codes);
    logic [3:0] n;
    buildSegs = '0;
    for (int k = 0; k < DIGITS; k++) begin
      n = codes[4*k +: 4];
      buildSegs[7*k +: 7] = (n <= 4'd12) ? glyph[n] : 7'b0101010;
    end
  endfunction

  // Frame-level reference: count identical complete frames, publish on reaching the target.
  task automatic modelFrame(input logic [4*DIGITS-1:0] cand);
    if (cand == mLast) begin
      if (mStable < 15) mStable++;
    end else begin
      mLast   = cand;
      mStable = 1;
    end
    if (mStable >= STABLE_FRAMES && (!mValid || mLast != mPub)) begin
      mPub   = mLast;
      mValid = 1'b1;
      expQ.push_back(mLast);
    end
  endtask

  task automatic applyStimulus(input logic [7*DIGITS-1:0] segs, input int dwell,
                               input int gap, input bit glitch);
    logic [4*DIGITS-1:0] cand;
    for (int k = 0; k < DIGITS; k++) cand[4*k +: 4] = decodeModel(segs[7*k +: 7]);
    if (dwell >= SETTLE) modelFrame(cand);
    if (glitch) mErr = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      an  = ~(DIGITS'(1) << k);
      seg = segs[7*k +: 7];
      repeat (dwell) @(negedge clk);
      an = '1;
      repeat (gap) @(negedge clk);
      if (glitch && k == 1) begin
        an = 4'b1100;
        @(negedge clk);
        an = '1;
      end
    end
  endtask

  task automatic idle(input int n);
    an = '1;
    repeat (n) @(negedge clk);
    if (n >= TIMEOUT + 10) begin
      mValid  = 1'b0;
      mStable = 0;
    end
  endtask

  task automatic checkOutput(input string tag);
    an = '1;
    repeat (8) @(negedge clk);
    check({tag, ".valid"},    32'(valid),    32'(mValid));
    check({tag, ".digits"},   32'(digits),   32'(mPub));
    check({tag, ".errMulti"}, 32'(errMulti), 32'(mErr));
  endtask

  // Monitor: every update pulse must match the oldest predicted publish.
  initial begin
    logic [4*DIGITS-1:0] exp;
    forever begin
      @(negedge clk);
      if (!rst && update) begin
        checkCount++;
        if (expQ.size() == 0) begin
          $display("[TB] FAIL unexpectedUpdate: got update with digits %0h, expected none", digits);
        end else begin
          passCount++;
          exp = expQ.pop_front();
          check("updateDigits", 32'(digits), 32'(exp));
          check("updateValid", 32'(valid), 32'(1));
        end
      end
    end
  end

  initial begin
    logic [7*DIGITS-1:0] segs;
    int reps, dwell, gap;
    glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
              7'b1011100, 7'b1100011, 7'b1111111};
    rst = 1'b1;
    an  = '1;
    seg = '1;
    repeat (3) @(negedge clk);
    check("reset.digits",   32'(digits),   32'(0));
    check("reset.valid",    32'(valid),    32'(0));
    check("reset.update",   32'(update),   32'(0));
    check("reset.errMulti", 32'(errMulti), 32'(0));
    rst = 1'b0;

    // Dwell shorter than SETTLE never samples.
    for (int f = 0; f < 3; f++) applyStimulus(buildSegs(16'h1234), SETTLE - 1, 1, 1'b0);
    checkOutput("short");
    idle(TIMEOUT + 20);
    checkOutput("shortTimeout");

    for (int f = 0; f < 3; f++) begin
      applyStimulus(buildSegs(16'hCC42), 8, 2, 1'b0);
      checkOutput("blank42");
    end

    applyStimulus(buildSegs(16'h0A07), 6, 1, 1'b0);
    applyStimulus(buildSegs(16'h0A07), 6, 1, 1'b0);
    checkOutput("steady07");
    applyStimulus(buildSegs(16'h0A08), 6, 1, 1'b0);
    checkOutput("change08a");
    applyStimulus(buildSegs(16'h0A08), 6, 1, 1'b0);
    checkOutput("change08b");

    applyStimulus(buildSegs(16'h0A08), 6, 1, 1'b1);
    checkOutput("glitch");
    applyStimulus(buildSegs(16'h0A08), 6, 0, 1'b0);
    checkOutput("glitchSticky");

    for (int f = 0; f < 2; f++) begin
      applyStimulus(buildSegs(16'h0AF8), 5, 0, 1'b0);
      checkOutput("invalidSeg");
    end

    for (int f = 0; f < 2; f++) applyStimulus(buildSegs(16'h1234), 7, 1, 1'b0);
    checkOutput("pub1234");
    idle(TIMEOUT + 20);
    checkOutput("timeout1234");
    applyStimulus(buildSegs(16'h1234), 7, 1, 1'b0);
    checkOutput("resume1");
    applyStimulus(buildSegs(16'h1234), 7, 1, 1'b0);
    checkOutput("resume2");

    for (int g = 0; g < 20; g++) begin
      for (int k = 0; k < DIGITS; k++) begin
        if ($urandom_range(0, 3) == 0) segs[7*k +: 7] = 7'($urandom);
        else segs[7*k +: 7] = glyph[$urandom_range(0, 12)];
      end
      reps  = $urandom_range(1, 3);
      dwell = $urandom_range(SETTLE, SETTLE + 5);
      gap   = $urandom_range(0, 3);
      for (int r = 0; r < reps; r++) applyStimulus(segs, dwell, gap, $urandom_range(0, 7) == 0);
      checkOutput("random");
    end

    repeat (10) @(negedge clk);
    check("pendingUpdates", 32'(expQ.size()), 32'(0));
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
